// File: rtl/store_queue_pkg.sv
// Shared types and constants for the LSU store queue.
package store_queue_pkg;

  // Default queue depth; must be a power of two and at least 2.
  localparam int SDQ_ENTRIES = 8;

  // Access size encoding carried in each entry.
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // One store queue slot as presented to the dcache write port.
  typedef struct packed {
    logic        vld;
    logic        addr_vld;
    logic        cmit;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
  } sdq_entry_t;

  // Advance a wrap-bit pointer by one when inc is set.
  function automatic logic [$clog2(SDQ_ENTRIES):0] ptr_inc(
    input logic [$clog2(SDQ_ENTRIES):0] ptr,
    input logic                         inc
  );
    return ptr + {{$clog2(SDQ_ENTRIES){1'b0}}, inc};
  endfunction

endpackage

// File: rtl/store_queue_if.sv
// Dispatch / AGU / ROB / dcache signal bundle of the store queue.
interface store_queue_if
  import store_queue_pkg::*;
#(
  parameter int SDQ_ENTRIES = store_queue_pkg::SDQ_ENTRIES,
  parameter int PW          = $clog2(SDQ_ENTRIES) + 1
);

  // Dispatch: allocate in program order, hand out the marker.
  logic          disp_vld;
  logic [PW-1:0] disp_sdq_idx;
  logic          disp_full;

  // Store AGU writeback.
  logic          exec_vld;
  logic [PW-2:0] exec_sdq_idx;
  logic [31:0]   exec_addr;
  logic [31:0]   exec_data;
  logic [1:0]    exec_size;

  // ROB retirement and squash.
  logic          cmit_vld;
  logic          flush;

  // Drain toward the data cache.
  logic          issue_vld;
  logic          issue_rdy;
  sdq_entry_t    issue_entry;
  logic [PW-1:0] sdq_head;

  // Store queue side.
  modport slave (
    input  disp_vld, exec_vld, exec_sdq_idx, exec_addr, exec_data, exec_size,
    input  cmit_vld, flush, issue_rdy,
    output disp_sdq_idx, disp_full, issue_vld, issue_entry, sdq_head
  );

  // Pipeline / dcache side driving the queue.
  modport master (
    output disp_vld, exec_vld, exec_sdq_idx, exec_addr, exec_data, exec_size,
    output cmit_vld, flush, issue_rdy,
    input  disp_sdq_idx, disp_full, issue_vld, issue_entry, sdq_head
  );

endinterface

// File: rtl/store_queue.sv
// Store queue: in-order allocate, out-of-order AGU fill, in-order commit
// and drain of committed stores to the dcache, one per cycle each.
module store_queue
  import store_queue_pkg::*;
#(
  parameter int SDQ_ENTRIES = store_queue_pkg::SDQ_ENTRIES,
  parameter int PW          = $clog2(SDQ_ENTRIES) + 1
) (
  input  logic         clk,
  input  logic         rst,
  store_queue_if.slave sq
);

  localparam int IW = PW - 1;

  // Pointers carry a wrap bit above the index so full and empty differ.
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] cptr_q, cptr_d;
  logic [PW-1:0] tail_q, tail_d;

  sdq_entry_t [SDQ_ENTRIES-1:0] entry_vec;
  sdq_entry_t                   head_ent;
  logic [PW-1:0]                occupancy;
  logic                         full;
  logic                         issue_ok;
  logic                         issue_fire;
  logic                         disp_fire;
  logic                         cmit_fire;
  logic [PW-1:0]                flush_cnt;

  // Status decoded purely from registered state.
  always_comb begin
    occupancy  = tail_q - head_q;
    full       = (occupancy == PW'(SDQ_ENTRIES));
    head_ent   = entry_vec[head_q[IW-1:0]];
    issue_ok   = head_ent.vld && head_ent.cmit && head_ent.addr_vld;
    issue_fire = issue_ok && sq.issue_rdy;
    // A flush squashes any dispatch arriving in the same cycle.
    disp_fire  = sq.disp_vld && !full && !sq.flush;
    cmit_fire  = sq.cmit_vld && (cptr_q != tail_q);
  end

  // Pointer next state; flush rewinds tail to the post-commit cptr.
  always_comb begin
    head_d    = head_q + {{IW{1'b0}}, issue_fire};
    cptr_d    = cptr_q + {{IW{1'b0}}, cmit_fire};
    tail_d    = tail_q + {{IW{1'b0}}, disp_fire};
    if (sq.flush) begin
      tail_d = cptr_d;
    end
    // Number of uncommitted entries squashed by a flush this cycle.
    flush_cnt = tail_q - cptr_d;
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      cptr_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      cptr_q <= cptr_d;
      tail_q <= tail_d;
    end
  end

  // One slot per generate iteration, each with its own update logic.
  for (genvar gi = 0; gi < SDQ_ENTRIES; gi++) begin : g_ent
    localparam logic [IW-1:0] IDX = IW'(gi);

    sdq_entry_t    ent_q, ent_d;
    logic [IW-1:0] flush_off;
    logic          flush_hit;

    // Slot lies in [cptr after commit, old tail) and is being squashed.
    always_comb begin
      flush_off = IDX - cptr_d[IW-1:0];
      flush_hit = sq.flush && ({1'b0, flush_off} < flush_cnt);
    end

    // Slot next state: allocation wins; otherwise fill, commit, drain, squash.
    always_comb begin
      ent_d = ent_q;
      if (disp_fire && (tail_q[IW-1:0] == IDX)) begin
        ent_d     = '0;
        ent_d.vld = 1'b1;
      end else begin
        // AGU writes to a free slot are stale and dropped.
        if (sq.exec_vld && (sq.exec_sdq_idx == IDX) && ent_q.vld) begin
          ent_d.addr     = sq.exec_addr;
          ent_d.data     = sq.exec_data;
          ent_d.size     = sq.exec_size;
          ent_d.addr_vld = 1'b1;
        end
        if (cmit_fire && (cptr_q[IW-1:0] == IDX)) begin
          ent_d.cmit = 1'b1;
        end
        if (issue_fire && (head_q[IW-1:0] == IDX)) begin
          ent_d.vld = 1'b0;
        end
        if (flush_hit) begin
          ent_d.vld = 1'b0;
        end
      end
    end

    // Slot register; reset empties the queue without draining.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        ent_q <= '0;
      end else begin
        ent_q <= ent_d;
      end
    end

    assign entry_vec[gi] = ent_q;
  end

  assign sq.disp_sdq_idx = tail_q;
  assign sq.disp_full    = full;
  assign sq.issue_vld    = issue_ok;
  assign sq.issue_entry  = head_ent;
  assign sq.sdq_head     = head_q;

endmodule

// File: tb/tb_store_queue.sv
// Directed bench for the store queue: reset, fill, ordering, backpressure,
// flush and pointer wrap.
module tb_store_queue;
  import store_queue_pkg::*;

  localparam int N  = 8;
  localparam int PW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  store_queue_if #(.SDQ_ENTRIES(N), .PW(PW)) sq ();

  store_queue #(.SDQ_ENTRIES(N), .PW(PW)) dut (
    .clk (clk),
    .rst (rst),
    .sq  (sq.slave)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic clear_inputs();
    sq.disp_vld     = 1'b0;
    sq.exec_vld     = 1'b0;
    sq.exec_sdq_idx = '0;
    sq.exec_addr    = '0;
    sq.exec_data    = '0;
    sq.exec_size    = SZ_B;
    sq.cmit_vld     = 1'b0;
    sq.flush        = 1'b0;
    sq.issue_rdy    = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    #3;
    rst = 1'b1;
    tick();
  endtask

  task automatic dispatch_n(input int n);
    for (int i = 0; i < n; i++) begin
      sq.disp_vld = 1'b1;
      $display("[tb] dispatch marker=%0d", sq.disp_sdq_idx);
      tick();
    end
    sq.disp_vld = 1'b0;
  endtask

  task automatic exec_op(input int idx, input logic [31:0] addr, input logic [31:0] data);
    sq.exec_vld     = 1'b1;
    sq.exec_sdq_idx = 3'(idx);
    sq.exec_addr    = addr;
    sq.exec_data    = data;
    sq.exec_size    = SZ_W;
    $display("[tb] exec idx=%0d addr=%h data=%h", idx, addr, data);
    tick();
    sq.exec_vld = 1'b0;
  endtask

  task automatic commit_op();
    sq.cmit_vld = 1'b1;
    $display("[tb] commit");
    tick();
    sq.cmit_vld = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    #2;
    checks++;
    if (sq.disp_sdq_idx !== 4'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", sq.disp_sdq_idx); end
    checks++;
    if (sq.disp_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", sq.disp_full); end
    checks++;
    if (sq.issue_vld !== 1'b0) begin errors++; $display("FAIL reset_issue_vld: got %b expected 0", sq.issue_vld); end
    checks++;
    if (sq.sdq_head !== 4'd0) begin errors++; $display("FAIL reset_head: got %0d expected 0", sq.sdq_head); end
    checks++;
    if (sq.issue_entry !== '0) begin errors++; $display("FAIL reset_entry: got %h expected 0", sq.issue_entry); end
    $display("[tb] reset checked");
  endtask

  task automatic test_reset_mid_fill();
    do_reset();
    dispatch_n(3);
    checks++;
    if (sq.disp_sdq_idx !== 4'd3) begin errors++; $display("FAIL midrst_pre_idx: got %0d expected 3", sq.disp_sdq_idx); end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (sq.disp_sdq_idx !== 4'd0) begin errors++; $display("FAIL midrst_idx: got %0d expected 0", sq.disp_sdq_idx); end
    checks++;
    if (sq.issue_vld !== 1'b0) begin errors++; $display("FAIL midrst_issue: got %b expected 0", sq.issue_vld); end
    checks++;
    if (sq.sdq_head !== 4'd0) begin errors++; $display("FAIL midrst_head: got %0d expected 0", sq.sdq_head); end
    rst = 1'b1;
    $display("[tb] async reset mid-fill");
  endtask

  task automatic test_full();
    do_reset();
    dispatch_n(7);
    checks++;
    if (sq.disp_full !== 1'b0) begin errors++; $display("FAIL full_at7: got %b expected 0", sq.disp_full); end
    dispatch_n(1);
    checks++;
    if (sq.disp_sdq_idx !== 4'd8) begin errors++; $display("FAIL full_idx: got %0d expected 8", sq.disp_sdq_idx); end
    checks++;
    if (sq.disp_full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b expected 1", sq.disp_full); end
    dispatch_n(1);
    checks++;
    if (sq.disp_sdq_idx !== 4'd8) begin errors++; $display("FAIL full_9th_idx: got %0d expected 8", sq.disp_sdq_idx); end
    checks++;
    if (sq.disp_full !== 1'b1) begin errors++; $display("FAIL full_9th_flag: got %b expected 1", sq.disp_full); end
  endtask

  task automatic test_ordering();
    do_reset();
    dispatch_n(2);
    exec_op(1, 32'h1000, 32'h11);
    exec_op(0, 32'h2000, 32'hAA);
    checks++;
    if (sq.issue_vld !== 1'b0) begin errors++; $display("FAIL ord_uncommitted: got %b expected 0", sq.issue_vld); end
    commit_op();
    checks++;
    if (sq.issue_vld !== 1'b1) begin errors++; $display("FAIL ord_issue_vld: got %b expected 1", sq.issue_vld); end
    checks++;
    if (sq.issue_entry.addr !== 32'h2000) begin errors++; $display("FAIL ord_addr0: got %h expected 2000", sq.issue_entry.addr); end
    checks++;
    if (sq.issue_entry.data !== 32'hAA) begin errors++; $display("FAIL ord_data0: got %h expected aa", sq.issue_entry.data); end
    sq.issue_rdy = 1'b1;
    $display("[tb] issue head");
    tick();
    sq.issue_rdy = 1'b0;
    checks++;
    if (sq.sdq_head !== 4'd1) begin errors++; $display("FAIL ord_head: got %0d expected 1", sq.sdq_head); end
    checks++;
    if (sq.issue_vld !== 1'b0) begin errors++; $display("FAIL ord_entry1_early: got %b expected 0", sq.issue_vld); end
    commit_op();
    checks++;
    if (sq.issue_vld !== 1'b1) begin errors++; $display("FAIL ord_entry1_vld: got %b expected 1", sq.issue_vld); end
    checks++;
    if (sq.issue_entry.addr !== 32'h1000) begin errors++; $display("FAIL ord_addr1: got %h expected 1000", sq.issue_entry.addr); end
  endtask

  task automatic test_backpressure();
    do_reset();
    dispatch_n(1);
    sq.cmit_vld = 1'b1;
    exec_op(0, 32'h3000, 32'h55);
    sq.cmit_vld = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (sq.issue_vld !== 1'b1) begin errors++; $display("FAIL bp_vld c%0d: got %b expected 1", c, sq.issue_vld); end
      checks++;
      if (sq.issue_entry.addr !== 32'h3000 || sq.issue_entry.data !== 32'h55) begin
        errors++; $display("FAIL bp_entry c%0d: got %h/%h expected 3000/55", c, sq.issue_entry.addr, sq.issue_entry.data);
      end
      $display("[tb] stall cycle %0d", c);
      tick();
    end
    checks++;
    if (sq.sdq_head !== 4'd0) begin errors++; $display("FAIL bp_head_held: got %0d expected 0", sq.sdq_head); end
    sq.issue_rdy = 1'b1;
    tick();
    sq.issue_rdy = 1'b0;
    checks++;
    if (sq.sdq_head !== 4'd1) begin errors++; $display("FAIL bp_head_adv: got %0d expected 1", sq.sdq_head); end
    checks++;
    if (sq.issue_vld !== 1'b0) begin errors++; $display("FAIL bp_vld_after: got %b expected 0", sq.issue_vld); end
  endtask

  task automatic test_flush();
    do_reset();
    dispatch_n(4);
    for (int i = 0; i < 4; i++) exec_op(i, 32'h4000 + 32'(i * 4), 32'(i));
    commit_op();
    sq.flush    = 1'b1;
    sq.disp_vld = 1'b1;
    $display("[tb] flush with dispatch");
    tick();
    clear_inputs();
    checks++;
    if (sq.disp_sdq_idx !== 4'd1) begin errors++; $display("FAIL flush_tail: got %0d expected 1", sq.disp_sdq_idx); end
    checks++;
    if (sq.issue_vld !== 1'b1 || sq.issue_entry.addr !== 32'h4000) begin
      errors++; $display("FAIL flush_e0: got vld=%b addr=%h expected vld=1 addr=4000", sq.issue_vld, sq.issue_entry.addr);
    end
    sq.issue_rdy = 1'b1;
    tick();
    checks++;
    if (sq.sdq_head !== 4'd1) begin errors++; $display("FAIL flush_head: got %0d expected 1", sq.sdq_head); end
    sq.cmit_vld = 1'b1;
    tick();
    tick();
    sq.cmit_vld = 1'b0;
    checks++;
    if (sq.issue_vld !== 1'b0) begin errors++; $display("FAIL flush_squashed_issue: got %b expected 0", sq.issue_vld); end
    checks++;
    if (sq.sdq_head !== 4'd1 || sq.disp_sdq_idx !== 4'd1) begin
      errors++; $display("FAIL flush_ptrs: got head=%0d tail=%0d expected 1/1", sq.sdq_head, sq.disp_sdq_idx);
    end
    sq.issue_rdy = 1'b0;
    dispatch_n(1);
    commit_op();
    checks++;
    if (sq.issue_vld !== 1'b0 || sq.issue_entry.cmit !== 1'b1 || sq.issue_entry.addr_vld !== 1'b0) begin
      errors++; $display("FAIL flush_realloc: got vld=%b cmit=%b addr_vld=%b expected 0/1/0",
                         sq.issue_vld, sq.issue_entry.cmit, sq.issue_entry.addr_vld);
    end
  endtask

  task automatic test_wrap();
    bit full_seen = 1'b0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      dispatch_n(1);
      if (sq.disp_full) full_seen = 1'b1;
      sq.cmit_vld = 1'b1;
      exec_op(i % 8, 32'h8000 + 32'(i), ~32'(i));
      sq.cmit_vld = 1'b0;
      checks++;
      if (sq.issue_vld !== 1'b1 || sq.issue_entry.addr !== 32'h8000 + 32'(i)) begin
        errors++; $display("FAIL wrap_issue i%0d: got vld=%b addr=%h expected 1/%h", i, sq.issue_vld, sq.issue_entry.addr, 32'h8000 + 32'(i));
      end
      sq.issue_rdy = 1'b1;
      tick();
      sq.issue_rdy = 1'b0;
      if (sq.disp_full) full_seen = 1'b1;
    end
    checks++;
    if (sq.sdq_head !== 4'd4) begin errors++; $display("FAIL wrap_head: got %0d expected 4", sq.sdq_head); end
    checks++;
    if (sq.disp_sdq_idx !== 4'd4) begin errors++; $display("FAIL wrap_tail: got %0d expected 4", sq.disp_sdq_idx); end
    checks++;
    if (full_seen !== 1'b0) begin errors++; $display("FAIL wrap_full: got %b expected 0", full_seen); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_fill();
    test_full();
    test_ordering();
    test_backpressure();
    test_flush();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
